mem_arbiter: RTL and testbench

- Shares the single main-memory port between instruction-cache miss traffic and data-cache miss/writeback traffic.
- Sits between the two cache controllers and the off-chip memory interface.
- Serialises the requests: one transaction outstanding at a time, round-robin grant on contention.
- Returns each response to the requester that issued it. Caches derive their pipeline stall from their own pending request.

---
 rtl/mem_arbiter.sv | 211 +++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Main-memory arbiter: serialises I-cache and D-cache miss/writeback traffic onto a single
// memory port. One transaction is outstanding at a time and contention is resolved round-robin.
// Each response is returned as a one-cycle registered pulse to the requester that issued it.
module mem_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 128
) (
    input  logic                clk,
    input  logic                reset,

    // I-cache side (reads only)
    input  logic                ic_req_valid,
    output logic                ic_req_ready,
    input  logic [ADDR_W-1:0]   ic_req_addr,
    output logic                ic_resp_valid,
    output logic [DATA_W-1:0]   ic_resp_data,

    // D-cache side (reads and writebacks)
    input  logic                dc_req_valid,
    output logic                dc_req_ready,
    input  logic                dc_req_rw,
    input  logic [ADDR_W-1:0]   dc_req_addr,
    input  logic [DATA_W-1:0]   dc_req_wdata,
    input  logic [DATA_W/8-1:0] dc_req_wmask,
    output logic                dc_resp_valid,
    output logic [DATA_W-1:0]   dc_resp_data,

    // Memory side
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic                mem_req_rw,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic [DATA_W-1:0]   mem_req_data,
    output logic [DATA_W/8-1:0] mem_req_mask,
    input  logic                mem_resp_valid,
    input  logic [DATA_W-1:0]   mem_resp_data,

    output logic                busy
);

    localparam int unsigned MaskW = DATA_W / 8;

    // Owner / last-grant encoding
    localparam logic OwnIc = 1'b0;
    localparam logic OwnDc = 1'b1;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StResp
    } state_e;

    state_e state_q, state_d;

    logic              last_grant_q, last_grant_d;
    logic              owner_q, owner_d;
    logic              rw_q, rw_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [MaskW-1:0]  mask_q, mask_d;

    logic              ic_resp_valid_q, ic_resp_valid_d;
    logic [DATA_W-1:0] ic_resp_data_q, ic_resp_data_d;
    logic              dc_resp_valid_q, dc_resp_valid_d;
    logic [DATA_W-1:0] dc_resp_data_q, dc_resp_data_d;

    logic ic_win, dc_win, grant;
    logic mem_hs, wr_done, rd_done;

    // Round-robin pick: on contention the side that did not win last time goes first
    always_comb begin
        dc_win = dc_req_valid && (!ic_req_valid || (last_grant_q == OwnIc));
        ic_win = ic_req_valid && !dc_win;
        grant  = (state_q == StIdle) && (ic_win || dc_win);
    end

    // Memory-side events that close a transaction
    always_comb begin
        mem_hs  = (state_q == StReq) && mem_req_ready;
        wr_done = mem_hs && rw_q;
        rd_done = (state_q == StResp) && mem_resp_valid;
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (grant) begin
                    state_d = StReq;
                end
            end
            StReq: begin
                if (mem_req_ready) begin
                    // Writes complete on the handshake; reads wait for data
                    state_d = rw_q ? StIdle : StResp;
                end
            end
            StResp: begin
                if (mem_resp_valid) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs: ready is only ever offered from IDLE
    always_comb begin
        ic_req_ready  = (state_q == StIdle) && ic_win;
        dc_req_ready  = (state_q == StIdle) && dc_win;
        mem_req_valid = (state_q == StReq);
        busy          = (state_q != StIdle);
    end

    // Request capture on the grant edge; I-side requests become full-line reads
    always_comb begin
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        rw_d         = rw_q;
        addr_d       = addr_q;
        data_d       = data_q;
        mask_d       = mask_q;
        if (grant) begin
            if (dc_win) begin
                last_grant_d = OwnDc;
                owner_d      = OwnDc;
                rw_d         = dc_req_rw;
                addr_d       = dc_req_addr;
                data_d       = dc_req_wdata;
                // Reads always fetch the whole line
                mask_d       = dc_req_rw ? dc_req_wmask : {MaskW{1'b1}};
            end else begin
                last_grant_d = OwnIc;
                owner_d      = OwnIc;
                rw_d         = 1'b0;
                addr_d       = ic_req_addr;
                data_d       = '0;
                mask_d       = {MaskW{1'b1}};
            end
        end
    end

    // Response steering: pulses last one cycle, data holds between pulses
    always_comb begin
        ic_resp_valid_d = rd_done && (owner_q == OwnIc);
        ic_resp_data_d  = ic_resp_valid_d ? mem_resp_data : ic_resp_data_q;
        dc_resp_valid_d = (rd_done && (owner_q == OwnDc)) || wr_done;
        dc_resp_data_d  = dc_resp_data_q;
        if (wr_done) begin
            dc_resp_data_d = '0;
        end else if (rd_done && (owner_q == OwnDc)) begin
            dc_resp_data_d = mem_resp_data;
        end
    end

    // Datapath and response registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant_q    <= OwnDc;
            owner_q         <= OwnIc;
            rw_q            <= 1'b0;
            addr_q          <= '0;
            data_q          <= '0;
            mask_q          <= '0;
            ic_resp_valid_q <= 1'b0;
            ic_resp_data_q  <= '0;
            dc_resp_valid_q <= 1'b0;
            dc_resp_data_q  <= '0;
        end else begin
            last_grant_q    <= last_grant_d;
            owner_q         <= owner_d;
            rw_q            <= rw_d;
            addr_q          <= addr_d;
            data_q          <= data_d;
            mask_q          <= mask_d;
            ic_resp_valid_q <= ic_resp_valid_d;
            ic_resp_data_q  <= ic_resp_data_d;
            dc_resp_valid_q <= dc_resp_valid_d;
            dc_resp_data_q  <= dc_resp_data_d;
        end
    end

    assign mem_req_rw    = rw_q;
    assign mem_req_addr  = addr_q;
    assign mem_req_data  = data_q;
    assign mem_req_mask  = mask_q;
    assign ic_resp_valid = ic_resp_valid_q;
    assign ic_resp_data  = ic_resp_data_q;
    assign dc_resp_valid = dc_resp_valid_q;
    assign dc_resp_data  = dc_resp_data_q;

`ifndef SYNTHESIS
    a_one_ready: assert property (@(posedge clk) disable iff (!reset)
        !(ic_req_ready && dc_req_ready));
    a_one_resp: assert property (@(posedge clk) disable iff (!reset)
        !(ic_resp_valid && dc_resp_valid));
    a_ready_idle: assert property (@(posedge clk) disable iff (!reset)
        (ic_req_ready || dc_req_ready) |-> !busy);
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic, every cycle compared
// against a transaction-level model of the arbiter.
module tb_mem_arbiter;

    logic         clk;
    logic         reset;
    logic         ic_req_valid;
    logic         ic_req_ready;
    logic [31:0]  ic_req_addr;
    logic         ic_resp_valid;
    logic [127:0] ic_resp_data;
    logic         dc_req_valid;
    logic         dc_req_ready;
    logic         dc_req_rw;
    logic [31:0]  dc_req_addr;
    logic [127:0] dc_req_wdata;
    logic [15:0]  dc_req_wmask;
    logic         dc_resp_valid;
    logic [127:0] dc_resp_data;
    logic         mem_req_valid;
    logic         mem_req_ready;
    logic         mem_req_rw;
    logic [31:0]  mem_req_addr;
    logic [127:0] mem_req_data;
    logic [15:0]  mem_req_mask;
    logic         mem_resp_valid;
    logic [127:0] mem_resp_data;
    logic         busy;

    int checks;
    int failures;

    mem_arbiter #(
        .ADDR_W(32),
        .DATA_W(128)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .ic_req_valid  (ic_req_valid),
        .ic_req_ready  (ic_req_ready),
        .ic_req_addr   (ic_req_addr),
        .ic_resp_valid (ic_resp_valid),
        .ic_resp_data  (ic_resp_data),
        .dc_req_valid  (dc_req_valid),
        .dc_req_ready  (dc_req_ready),
        .dc_req_rw     (dc_req_rw),
        .dc_req_addr   (dc_req_addr),
        .dc_req_wdata  (dc_req_wdata),
        .dc_req_wmask  (dc_req_wmask),
        .dc_resp_valid (dc_resp_valid),
        .dc_resp_data  (dc_resp_data),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_rw    (mem_req_rw),
        .mem_req_addr  (mem_req_addr),
        .mem_req_data  (mem_req_data),
        .mem_req_mask  (mem_req_mask),
        .mem_resp_valid(mem_resp_valid),
        .mem_resp_data (mem_resp_data),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- transaction-level model ----------------
    typedef struct {
        bit           from_dc;
        bit           write;
        logic [31:0]  addr;
        logic [127:0] data;
        logic [15:0]  mask;
    } txn_t;

    txn_t         inflight[$];   // at most one outstanding transaction
    bit           mem_took_it;   // memory has accepted the inflight request
    bit           last_was_dc;
    bit           pulse_ic, pulse_dc;
    logic [127:0] held_ic, held_dc;

    task automatic model_reset();
        inflight.delete();
        mem_took_it = 1'b0;
        last_was_dc = 1'b1;
        pulse_ic    = 1'b0;
        pulse_dc    = 1'b0;
        held_ic     = '0;
        held_dc     = '0;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare all outputs against the model, then advance the model across the coming edge
    task automatic model_step();
        bit   idle, pick_dc, any_req, exp_mreq;
        txn_t t;
        if (!reset) model_reset();
        idle     = (inflight.size() == 0);
        any_req  = ic_req_valid || dc_req_valid;
        pick_dc  = dc_req_valid && (!ic_req_valid || !last_was_dc);
        exp_mreq = !idle && !mem_took_it;

        chk("ic_req_ready", ic_req_ready, idle && any_req && !pick_dc);
        chk("dc_req_ready", dc_req_ready, idle && pick_dc);
        chk("busy", busy, !idle);
        chk("mem_req_valid", mem_req_valid, exp_mreq);
        if (exp_mreq) begin
            chk("mem_req_rw", mem_req_rw, inflight[0].write);
            chk("mem_req_addr", mem_req_addr, inflight[0].addr);
            chk("mem_req_data", mem_req_data, inflight[0].data);
            chk("mem_req_mask", mem_req_mask, inflight[0].mask);
        end
        chk("ic_resp_valid", ic_resp_valid, pulse_ic);
        chk("dc_resp_valid", dc_resp_valid, pulse_dc);
        chk("ic_resp_data", ic_resp_data, held_ic);
        chk("dc_resp_data", dc_resp_data, held_dc);

        if (!reset) return;
        pulse_ic = 1'b0;
        pulse_dc = 1'b0;
        if (idle) begin
            if (any_req) begin
                t.from_dc = pick_dc;
                t.write   = pick_dc && dc_req_rw;
                t.addr    = pick_dc ? dc_req_addr : ic_req_addr;
                t.data    = pick_dc ? dc_req_wdata : '0;
                t.mask    = t.write ? dc_req_wmask : 16'hFFFF;
                inflight.push_back(t);
                mem_took_it = 1'b0;
                last_was_dc = pick_dc;
            end
        end else if (!mem_took_it) begin
            if (mem_req_ready) begin
                if (inflight[0].write) begin
                    void'(inflight.pop_front());
                    pulse_dc = 1'b1;
                    held_dc  = '0;
                end else begin
                    mem_took_it = 1'b1;
                end
            end
        end else if (mem_resp_valid) begin
            t = inflight.pop_front();
            mem_took_it = 1'b0;
            if (t.from_dc) begin
                pulse_dc = 1'b1;
                held_dc  = mem_resp_data;
            end else begin
                pulse_ic = 1'b1;
                held_ic  = mem_resp_data;
            end
        end
    endtask

    // half: go to the sampling point and run the model; edge: cross the next rising edge
    task automatic half();
        @(negedge clk);
        model_step();
    endtask

    task automatic edge_();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            half();
            edge_();
        end
    endtask

    task automatic idle_inputs();
        ic_req_valid   = 1'b0;
        ic_req_addr    = '0;
        dc_req_valid   = 1'b0;
        dc_req_rw      = 1'b0;
        dc_req_addr    = '0;
        dc_req_wdata   = '0;
        dc_req_wmask   = '0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
    endtask

    int           grants;
    logic [127:0] wdata;

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        idle_inputs();
        model_reset();
        #2;
        chk("reset_busy", busy, 1'b0);
        chk("reset_mem_req_valid", mem_req_valid, 1'b0);
        chk("reset_mem_req_mask", mem_req_mask, 16'h0000);
        chk("reset_ic_resp_data", ic_resp_data, '0);
        edge_();
        edge_();
        reset = 1'b1;

        // Single IC read, memory data two cycles after the handshake
        ic_req_valid  = 1'b1;
        ic_req_addr   = 32'h100;
        mem_req_ready = 1'b1;
        half();
        chk("t1_ic_ready", ic_req_ready, 1'b1);
        chk("t1_dc_ready", dc_req_ready, 1'b0);
        edge_();
        ic_req_valid = 1'b0;
        half();
        chk("t1_mem_addr", mem_req_addr, 32'h100);
        chk("t1_mem_rw", mem_req_rw, 1'b0);
        chk("t1_mem_mask", mem_req_mask, 16'hFFFF);
        edge_();
        mem_req_ready = 1'b0;
        cyc(1);
        mem_resp_valid = 1'b1;
        mem_resp_data  = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_FEED_F00D;
        half();
        chk("t1_no_early_resp", ic_resp_valid, 1'b0);
        edge_();
        mem_resp_valid = 1'b0;
        half();
        chk("t1_ic_resp_valid", ic_resp_valid, 1'b1);
        chk("t1_ic_resp_data", ic_resp_data, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_FEED_F00D);
        chk("t1_dc_resp_valid", dc_resp_valid, 1'b0);
        edge_();

        // DC write with four memory wait states
        wdata        = {$urandom, $urandom, $urandom, $urandom};
        dc_req_valid = 1'b1;
        dc_req_rw    = 1'b1;
        dc_req_addr  = 32'h2A0;
        dc_req_wdata = wdata;
        dc_req_wmask = 16'h00F0;
        half();
        chk("t3_dc_ready", dc_req_ready, 1'b1);
        edge_();
        dc_req_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            mem_req_ready = (i == 4);
            half();
            chk("t3_mem_valid", mem_req_valid, 1'b1);
            chk("t3_mem_addr", mem_req_addr, 32'h2A0);
            chk("t3_mem_mask", mem_req_mask, 16'h00F0);
            chk("t3_mem_rw", mem_req_rw, 1'b1);
            chk("t3_mem_data", mem_req_data, wdata);
            edge_();
        end
        mem_req_ready = 1'b0;
        half();
        chk("t3_dc_resp_valid", dc_resp_valid, 1'b1);
        chk("t3_dc_resp_data", dc_resp_data, '0);
        chk("t3_ic_resp_valid", ic_resp_valid, 1'b0);
        edge_();

        // Contention with both requesters held valid
        ic_req_valid   = 1'b1;
        ic_req_addr    = 32'h200;
        dc_req_valid   = 1'b1;
        dc_req_rw      = 1'b0;
        dc_req_addr    = 32'h300;
        mem_req_ready  = 1'b1;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 128'h1111;
        for (int c = 0; c < 7; c++) begin
            half();
            if (c == 0) chk("t2_first_ic", ic_req_ready, 1'b1);
            if (c == 3) begin
                chk("t2_ic_resp", ic_resp_valid, 1'b1);
                chk("t2_second_dc", dc_req_ready, 1'b1);
            end
            if (c == 6) begin
                chk("t2_dc_resp", dc_resp_valid, 1'b1);
                chk("t2_third_ic", ic_req_ready, 1'b1);
            end
            edge_();
        end
        ic_req_valid = 1'b0;
        dc_req_valid = 1'b0;
        cyc(4);

        // Spurious memory responses in IDLE and in REQ
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 128'hBAD;
        half();
        chk("t4_idle_busy", busy, 1'b0);
        edge_();
        ic_req_valid = 1'b1;
        ic_req_addr  = 32'h380;
        cyc(1);
        ic_req_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            half();
            chk("t4_req_no_ic_pulse", ic_resp_valid, 1'b0);
            chk("t4_req_still_valid", mem_req_valid, 1'b1);
            edge_();
        end
        mem_req_ready  = 1'b1;
        mem_resp_valid = 1'b0;
        cyc(1);
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 128'h5A5A;
        cyc(2);
        mem_resp_valid = 1'b0;

        // Asynchronous reset while an IC read waits in RESP
        ic_req_valid  = 1'b1;
        ic_req_addr   = 32'h400;
        mem_req_ready = 1'b1;
        cyc(1);
        ic_req_valid = 1'b0;
        cyc(1);
        reset = 1'b0;
        #1;
        chk("t5_busy", busy, 1'b0);
        chk("t5_mem_req_valid", mem_req_valid, 1'b0);
        chk("t5_ic_resp_valid", ic_resp_valid, 1'b0);
        chk("t5_ic_resp_data", ic_resp_data, '0);
        chk("t5_dc_resp_data", dc_resp_data, '0);
        chk("t5_mem_req_addr", mem_req_addr, '0);
        model_reset();
        cyc(1);
        reset          = 1'b1;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 128'hCAFE;
        cyc(1);
        mem_resp_valid = 1'b0;
        half();
        chk("t5_late_resp_ignored", ic_resp_valid, 1'b0);
        edge_();
        ic_req_valid = 1'b1;
        ic_req_addr  = 32'h440;
        half();
        chk("t5_regrant", ic_req_ready, 1'b1);
        edge_();
        ic_req_valid   = 1'b0;
        mem_resp_valid = 1'b1;
        cyc(3);
        mem_resp_valid = 1'b0;

        // Back-to-back DC writes with a zero-wait memory
        grants        = 0;
        dc_req_valid  = 1'b1;
        dc_req_rw     = 1'b1;
        dc_req_wmask  = 16'hFFFF;
        mem_req_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            dc_req_addr  = 32'h1000 + 32'(i);
            dc_req_wdata = {4{$urandom}};
            half();
            if (dc_req_ready) grants++;
            edge_();
        end
        chk("t6_grant_count", grants, 4);
        dc_req_valid = 1'b0;
        cyc(2);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            ic_req_valid   = ($urandom_range(0, 2) != 0);
            ic_req_addr    = $urandom;
            dc_req_valid   = ($urandom_range(0, 2) != 0);
            dc_req_rw      = 1'($urandom_range(0, 1));
            dc_req_addr    = $urandom;
            dc_req_wdata   = {$urandom, $urandom, $urandom, $urandom};
            dc_req_wmask   = 16'($urandom_range(0, 65535));
            mem_req_ready  = ($urandom_range(0, 3) != 0);
            mem_resp_valid = ($urandom_range(0, 2) == 0);
            mem_resp_data  = {$urandom, $urandom, $urandom, $urandom};
            cyc(1);
        end
        idle_inputs();
        cyc(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
